// File: rtl/axi_ahb_w_sched_pkg.sv
// Shared constants for the AXI-to-AHB bridge write path.
package axi_ahb_w_sched_pkg;

  localparam int PIPE_DEPTH_DEF = 2;

  // Width that can hold every count from 0 up to and including depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/w_sched_token_pipe.sv
// Token shift register tracking write beats through the AHB address/data stages.
module w_sched_token_pipe
  import axi_ahb_w_sched_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hready,
  input  logic                  flush,
  input  logic                  issue,
  output logic [PIPE_DEPTH-1:0] valid,
  output logic                  done
);

  logic [PIPE_DEPTH-1:0] valid_nxt;

  generate
    if (PIPE_DEPTH == 1) begin : g_single
      assign valid_nxt = issue;
    end else begin : g_multi
      assign valid_nxt = {valid[PIPE_DEPTH-2:0], issue};
    end
  endgenerate

  // Flush discards tokens without completing them, so no pops are generated.
  assign done = rst_n & hready & ~flush & valid[PIPE_DEPTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid <= '0;
    end else if (hready) begin
      valid <= valid_nxt;
    end
  end

endmodule

// File: rtl/axi_ahb_w_sched.sv
// Write-issue scheduler: requests a beat only when AW/W/B FIFOs cover all in-flight beats plus one.
module axi_ahb_w_sched
  import axi_ahb_w_sched_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int CNT_W      = cnt_w(PIPE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIPE_DEPTH:0] aw_empty,
  input  logic [PIPE_DEPTH:0] w_empty,
  input  logic [PIPE_DEPTH:0] b_full,
  input  logic              grant,
  input  logic              hready,
  input  logic              flush,
  output logic              w_req,
  output logic              w_issue,
  output logic              aw_pop,
  output logic              w_pop,
  output logic              b_push,
  output logic [CNT_W-1:0]  inflight,
  output logic              busy
);

  logic [PIPE_DEPTH-1:0] valid;
  logic                  done;

  // Registered count indexes the lookahead flags, so a same-cycle completion
  // is not credited; the request is conservative by one beat.
  assign w_req   = ~aw_empty[inflight] & ~w_empty[inflight] & ~b_full[inflight];
  assign w_issue = rst_n & w_req & grant & hready & ~flush;

  assign aw_pop = done;
  assign w_pop  = done;
  assign b_push = done;
  assign busy   = (inflight != '0);

  w_sched_token_pipe #(
    .PIPE_DEPTH(PIPE_DEPTH)
  ) u_token_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .hready (hready),
    .flush  (flush),
    .issue  (w_issue),
    .valid  (valid),
    .done   (done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      inflight <= '0;
    end else if (hready) begin
      if (w_issue && !done) begin
        inflight <= inflight + CNT_W'(1);
      end else if (done && !w_issue) begin
        inflight <= inflight - CNT_W'(1);
      end
    end
  end

  a_count_matches: assert property (@(posedge clk) disable iff (!rst_n)
    inflight == CNT_W'($countones(valid)));

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    aw_pop |-> !aw_empty[0]);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    b_push |-> !b_full[0]);

endmodule

// File: tb/tb_axi_ahb_w_sched.sv
// Bench: directed vector table on a depth-2 instance, randomized model check on a depth-4 instance.
module tb_axi_ahb_w_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // depth-2 instance
  logic       rst_n2, grant2, hready2, flush2;
  logic [2:0] aw_e2, w_e2, b_f2;
  logic       req2, iss2, awp2, wp2, bp2, busy2;
  logic [1:0] infl2;

  // depth-4 instance
  logic       rst_n4, grant4, hready4, flush4;
  logic [4:0] aw_e4, w_e4, b_f4;
  logic       req4, iss4, awp4, wp4, bp4, busy4;
  logic [2:0] infl4;

  axi_ahb_w_sched #(.PIPE_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .aw_empty(aw_e2), .w_empty(w_e2), .b_full(b_f2),
    .grant(grant2), .hready(hready2), .flush(flush2),
    .w_req(req2), .w_issue(iss2), .aw_pop(awp2), .w_pop(wp2), .b_push(bp2),
    .inflight(infl2), .busy(busy2)
  );

  axi_ahb_w_sched #(.PIPE_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .aw_empty(aw_e4), .w_empty(w_e4), .b_full(b_f4),
    .grant(grant4), .hready(hready4), .flush(flush4),
    .w_req(req4), .w_issue(iss4), .aw_pop(awp4), .w_pop(wp4), .b_push(bp4),
    .inflight(infl4), .busy(busy4)
  );

  // Lookahead flag vector: bit k set when the count is <= k.
  function automatic logic [4:0] le_flags(input int cnt);
    logic [4:0] f;
    for (int k = 0; k < 5; k++) f[k] = (cnt <= k);
    return f;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst_n;
    int   aw, w, bf;
    logic g, h, f;
    logic req, iss, pop;
    int   infl;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [4:0] t;
    int aw, w, bf, k, q_hit;
    logic r, g, h, f, e_req, e_iss, e_done;
    int stg[$];
    int nq[$];

    rst_n2 = 0; grant2 = 0; hready2 = 0; flush2 = 0;
    aw_e2 = '1; w_e2 = '1; b_f2 = '1;
    rst_n4 = 0; grant4 = 0; hready4 = 0; flush4 = 0;
    aw_e4 = '1; w_e4 = '1; b_f4 = '1;
    repeat (2) @(posedge clk);

    //           rst  aw w  bf  g  h  f   req iss pop infl
    tbl.push_back('{1'b0, 1, 1, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0}); // strobes gated in reset
    tbl.push_back('{1'b1, 1, 1, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0}); // single beat issues
    tbl.push_back('{1'b1, 1, 1, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1}); // aw_empty[1] blocks
    tbl.push_back('{1'b1, 1, 1, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1}); // beat completes
    tbl.push_back('{1'b1, 3, 3, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0}); // 3-entry streaming
    tbl.push_back('{1'b1, 3, 3, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 3, 3, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2}); // full pipe still issues
    tbl.push_back('{1'b1, 5, 5, 5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2});
    tbl.push_back('{1'b1, 4, 4, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2}); // stall x3
    tbl.push_back('{1'b1, 4, 4, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2});
    tbl.push_back('{1'b1, 4, 4, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2});
    tbl.push_back('{1'b1, 4, 4, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2}); // resume
    tbl.push_back('{1'b1, 3, 3, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2}); // flush
    tbl.push_back('{1'b1, 3, 3, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 3, 3, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0}); // one B slot
    tbl.push_back('{1'b1, 3, 3, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b1, 3, 3, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1});
    tbl.push_back('{1'b1, 2, 2, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0}); // slot back
    tbl.push_back('{1'b1, 2, 2, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b0, 2, 2, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1}); // reset mid-stream
    tbl.push_back('{1'b1, 2, 2, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n2 = tbl[i].rst_n; grant2 = tbl[i].g; hready2 = tbl[i].h; flush2 = tbl[i].f;
      t = le_flags(tbl[i].aw); aw_e2 = t[2:0];
      t = le_flags(tbl[i].w);  w_e2  = t[2:0];
      t = le_flags(tbl[i].bf); b_f2  = t[2:0];
      #1;
      chk($sformatf("row%0d w_req", i),    req2,  tbl[i].req);
      chk($sformatf("row%0d w_issue", i),  iss2,  tbl[i].iss);
      chk($sformatf("row%0d aw_pop", i),   awp2,  tbl[i].pop);
      chk($sformatf("row%0d w_pop", i),    wp2,   tbl[i].pop);
      chk($sformatf("row%0d b_push", i),   bp2,   tbl[i].pop);
      chk($sformatf("row%0d inflight", i), infl2, tbl[i].infl);
      chk($sformatf("row%0d busy", i),     busy2, tbl[i].infl != 0);
    end

    // Randomized sweep: beats are tracked as a list of stage positions.
    aw = 0; w = 0; bf = 4;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      r = (cyc < 2) ? 1'b0 : ($urandom_range(0, 59) != 0 && cyc != 250);
      g = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 24) == 0);
      rst_n4 = r; grant4 = g; hready4 = h; flush4 = f;
      aw_e4 = le_flags(aw); w_e4 = le_flags(w); b_f4 = le_flags(bf);
      #1;
      k = stg.size();
      q_hit = 0;
      foreach (stg[j]) if (stg[j] == 3) q_hit = 1;
      e_req  = (aw > k) && (w > k) && (bf > k);
      e_iss  = r && e_req && g && h && !f;
      e_done = r && h && !f && (q_hit != 0);
      if (cyc >= 2) begin
        chk($sformatf("rnd%0d w_req", cyc),    req4,  e_req);
        chk($sformatf("rnd%0d w_issue", cyc),  iss4,  e_iss);
        chk($sformatf("rnd%0d aw_pop", cyc),   awp4,  e_done);
        chk($sformatf("rnd%0d w_pop", cyc),    wp4,   e_done);
        chk($sformatf("rnd%0d b_push", cyc),   bp4,   e_done);
        chk($sformatf("rnd%0d inflight", cyc), infl4, k);
        chk($sformatf("rnd%0d busy", cyc),     busy4, k != 0);
        chk($sformatf("rnd%0d infl_le4", cyc), infl4 <= 4, 1);
      end
      if (!r || f) begin
        stg.delete();
      end else if (h) begin
        nq.delete();
        foreach (stg[j]) if (stg[j] < 3) nq.push_back(stg[j] + 1);
        if (e_iss) nq.push_back(0);
        stg = nq;
      end
      if (e_done) begin
        aw--; w--; bf--;
      end
      if (aw < 7 && $urandom_range(0, 2) != 0) aw++;
      if (w < 7 && $urandom_range(0, 2) != 0) w++;
      if (bf < 7 && $urandom_range(0, 2) != 0) bf++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
